// File: rtl/task_9_output_if.sv
// -----------------------------------------------------------------------------
// task_9_output_if
// AXI-Stream byte channel carried between task_9_output and its sink.
//   o_tdata  : 8-bit payload byte           (master -> slave)
//   o_tvalid : beat valid                   (master -> slave)
//   o_tlast  : final beat of the packet     (master -> slave)
//   i_tready : sink can accept a beat       (slave  -> master)
// Signal names keep the o_/i_ prefixes as seen from the master side.
// -----------------------------------------------------------------------------
interface task_9_output_if;
   logic [7:0] o_tdata;
   logic       o_tvalid;
   logic       o_tlast;
   logic       i_tready;

   modport master (
      output o_tdata,
      output o_tvalid,
      output o_tlast,
      input  i_tready
   );

   modport slave (
      input  o_tdata,
      input  o_tvalid,
      input  o_tlast,
      output i_tready
   );
endinterface : task_9_output_if

// File: rtl/task_9_output.sv
// -----------------------------------------------------------------------------
// task_9_output
// Captures one contiguous burst of strobed bytes from the task_9 input stage
// into a packet buffer, then replays it as an AXI-Stream packet with o_tlast
// on the final beat.
//
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_data       : byte from the upstream stage, valid when i_enb=1
//   i_enb        : byte strobe
//   axis         : AXI-Stream master (o_tdata, o_tvalid, o_tlast, i_tready)
//   o_pkt_len    : payload byte count of the last captured packet
//   o_busy       : high whenever a packet is being collected, sent or closed
//   o_done       : one-cycle pulse after the last beat has transferred
//   o_ovf        : sticky, set whenever an incoming byte had to be dropped
//
// Build option
//   TASK_9_OUTPUT_CKSUM_EN : when defined, a mod-256 sum of the accepted
//   payload is appended as one extra beat, which then carries o_tlast.
//   o_pkt_len still counts payload bytes only.
//
// Parameters
//   DEPTH : buffer depth in bytes, power of two, at least 4
//   AW    : log2(DEPTH)
// -----------------------------------------------------------------------------
module task_9_output #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_data,
   input  logic                 i_enb,
   task_9_output_if.master      axis,
   output logic [AW:0]          o_pkt_len,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state_q,  state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic [AW:0]   pkt_len_q, pkt_len_d;
   logic          ovf_q,    ovf_d;
`ifdef TASK_9_OUTPUT_CKSUM_EN
   logic [7:0]    cksum_q,  cksum_d;
   logic          cks_phase_q, cks_phase_d;  // high while the checksum beat is offered
`endif

   logic [7:0]    buf_q [DEPTH];
   logic          wr_en;
   logic          last_payload;

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      pkt_len_d     = pkt_len_q;
      ovf_d         = ovf_q;
`ifdef TASK_9_OUTPUT_CKSUM_EN
      cksum_d       = cksum_q;
      cks_phase_d   = cks_phase_q;
`endif
      wr_en         = 1'b0;
      axis.o_tdata  = 8'h00;
      axis.o_tvalid = 1'b0;
      axis.o_tlast  = 1'b0;
      o_done        = 1'b0;

      // Pointers never wrap inside a packet, so rd_ptr==count-1 marks the end.
      last_payload  = ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));

      unique case (state_q)
         S_IDLE: begin
            // wr_ptr is always zero here, so the first byte lands at address 0.
            if (i_enb) begin
               wr_en    = 1'b1;
               wr_ptr_d = AW'(1);
               count_d  = (AW+1)'(1);
`ifdef TASK_9_OUTPUT_CKSUM_EN
               cksum_d  = i_data;
`endif
               state_d  = S_COLLECT;
            end
         end

         S_COLLECT: begin
            if (i_enb) begin
               if (count_q == FULL_CNT) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_q + (AW+1)'(1);
`ifdef TASK_9_OUTPUT_CKSUM_EN
                  cksum_d  = cksum_q + i_data;
`endif
               end
            end else begin
               pkt_len_d = count_q;
               state_d   = S_SEND;
            end
         end

         S_SEND: begin
            if (i_enb) ovf_d = 1'b1;
            axis.o_tvalid = 1'b1;
`ifdef TASK_9_OUTPUT_CKSUM_EN
            if (cks_phase_q) begin
               axis.o_tdata = cksum_q;
               axis.o_tlast = 1'b1;
            end else begin
               axis.o_tdata = buf_q[rd_ptr_q];
            end
            if (axis.i_tready) begin
               if (cks_phase_q)       state_d     = S_DONE;
               else if (last_payload) cks_phase_d = 1'b1;
               else                   rd_ptr_d    = rd_ptr_q + AW'(1);
            end
`else
            axis.o_tdata = buf_q[rd_ptr_q];
            axis.o_tlast = last_payload;
            if (axis.i_tready) begin
               if (last_payload) state_d  = S_DONE;
               else              rd_ptr_d = rd_ptr_q + AW'(1);
            end
`endif
         end

         S_DONE: begin
            if (i_enb) ovf_d = 1'b1;
            o_done   = 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
`ifdef TASK_9_OUTPUT_CKSUM_EN
            cksum_d     = 8'h00;
            cks_phase_d = 1'b0;
`endif
            state_d  = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign o_busy    = (state_q != S_IDLE);
   assign o_pkt_len = pkt_len_q;
   assign o_ovf     = ovf_q;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pkt_len_q <= '0;
         ovf_q     <= 1'b0;
`ifdef TASK_9_OUTPUT_CKSUM_EN
         cksum_q     <= 8'h00;
         cks_phase_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pkt_len_q <= pkt_len_d;
         ovf_q     <= ovf_d;
`ifdef TASK_9_OUTPUT_CKSUM_EN
         cksum_q     <= cksum_d;
         cks_phase_q <= cks_phase_d;
`endif
      end
   end

   // NOTE: the packet buffer is deliberately not reset; only locations below
   // count are ever read, and count restarts from zero after reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) buf_q[wr_ptr_q] <= i_data;
   end

endmodule : task_9_output

// File: tb/tb_task_9_output.sv
// -----------------------------------------------------------------------------
// tb_task_9_output
// Randomized self-checking bench for task_9_output (DEPTH=4). A queue-based
// model derives the expected beats, packet length, checksum and sticky
// overflow flag directly from the packet-level rules.
// -----------------------------------------------------------------------------
module tb_task_9_output;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [7:0]    i_data;
   logic          i_enb;
   logic [AW:0]   o_pkt_len;
   logic          o_busy;
   logic          o_done;
   logic          o_ovf;

   task_9_output_if axis ();

   task_9_output #(.DEPTH(DEPTH), .AW(AW)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_data    (i_data),
      .i_enb     (i_enb),
      .axis      (axis),
      .o_pkt_len (o_pkt_len),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_ovf     (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   bit exp_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode: 0 random ready, 1 ready always high, 2 ready alternating from 0
   task automatic run_pkt(input logic [7:0] pkt[$], input int mode, input bit inject);
      logic [7:0] exp_q[$];
      logic [7:0] sum;
      int         exp_len;
      int         beats;
      int         cyc;
      bit         done_ok;

      // reference model: first DEPTH bytes kept, the rest dropped and flagged
      sum = 8'h00;
      foreach (pkt[i]) begin
         if (i < DEPTH) begin
            exp_q.push_back(pkt[i]);
            sum = sum + pkt[i];
         end else begin
            exp_ovf = 1'b1;
         end
      end
      exp_len = exp_q.size();
`ifdef TASK_9_OUTPUT_CKSUM_EN
      exp_q.push_back(sum);
`endif

      foreach (pkt[i]) begin
         @(negedge i_clk);
         i_enb  = 1'b1;
         i_data = pkt[i];
      end
      @(negedge i_clk);
      i_enb  = 1'b0;
      i_data = 8'($urandom);
      check("busy_collect", o_busy, 1);
      check("tvalid_before_send", axis.o_tvalid, 0);

      @(negedge i_clk);
      check("tvalid_rise", axis.o_tvalid, 1);
      check("pkt_len", o_pkt_len, exp_len);

      beats   = 0;
      cyc     = 0;
      done_ok = 1'b0;
      while (!done_ok && cyc < 200) begin
         case (mode)
            0:       axis.i_tready = 1'($urandom_range(0, 1));
            1:       axis.i_tready = 1'b1;
            default: axis.i_tready = cyc[0];
         endcase
         if (inject && $urandom_range(0, 7) == 0) begin
            i_enb   = 1'b1;
            i_data  = 8'($urandom);
            exp_ovf = 1'b1;
         end else begin
            i_enb = 1'b0;
         end
         // the offered beat must match the model every cycle, stalled or not
         check("tvalid_held", axis.o_tvalid, 1);
         check("tdata", axis.o_tdata, exp_q[beats]);
         check("tlast", axis.o_tlast, (beats == exp_q.size() - 1) ? 1 : 0);
         if (axis.i_tready) begin
            beats++;
            if (beats == exp_q.size()) done_ok = 1'b1;
         end
         cyc++;
         @(negedge i_clk);
      end
      i_enb = 1'b0;
      if (!done_ok) check("beat_timeout", 0, 1);

      check("tvalid_after_last", axis.o_tvalid, 0);
      check("tlast_after_last", axis.o_tlast, 0);
      check("done_pulse", o_done, 1);
      check("busy_done", o_busy, 1);
      @(negedge i_clk);
      check("done_single", o_done, 0);
      check("busy_idle", o_busy, 0);
      check("pkt_len_held", o_pkt_len, exp_len);
      check("ovf", o_ovf, exp_ovf);
   endtask

   initial begin
      logic [7:0] pkt[$];
      int         len;

      i_rst         = 1'b1;
      i_enb         = 1'b0;
      i_data        = 8'h00;
      axis.i_tready = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst_tvalid", axis.o_tvalid, 0);
      check("rst_tlast", axis.o_tlast, 0);
      check("rst_tdata", axis.o_tdata, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_ovf", o_ovf, 0);
      check("rst_pkt_len", o_pkt_len, 0);
      i_rst = 1'b0;

      // basic, backpressure, single byte, checksum pattern, overflow
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_pkt(pkt, 1, 1'b0);
      run_pkt(pkt, 2, 1'b0);
      pkt = '{8'hA5};
      run_pkt(pkt, 1, 1'b0);
      pkt = '{8'hF0, 8'h20};
      run_pkt(pkt, 1, 1'b0);
      pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_pkt(pkt, 1, 1'b0);

      // random packets, including overflow and late-strobe drops
      for (int n = 0; n < 30; n++) begin
         pkt = {};
         len = $urandom_range(1, DEPTH + 3);
         for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
         run_pkt(pkt, 0, 1'($urandom_range(0, 1)));
      end

      // reset after two of four beats discards the packet and clears status
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (pkt[i]) begin
         @(negedge i_clk);
         i_enb  = 1'b1;
         i_data = pkt[i];
      end
      @(negedge i_clk);
      i_enb = 1'b0;
      @(negedge i_clk);
      axis.i_tready = 1'b1;
      check("mid_beat0", axis.o_tdata, 8'h11);
      @(negedge i_clk);
      check("mid_beat1", axis.o_tdata, 8'h22);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst   = 1'b0;
      exp_ovf = 1'b0;
      check("mid_rst_tvalid", axis.o_tvalid, 0);
      check("mid_rst_ovf", o_ovf, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_pkt_len", o_pkt_len, 0);
      pkt = '{8'hBE, 8'hEF};
      run_pkt(pkt, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_task_9_output
